// File: rtl/uart_tx_buf.sv
// -----------------------------------------------------------------------------
// uart_tx_buf
//
// Byte FIFO plus launch sequencer placed directly in front of uart_tx. Producers
// push bytes at up to one per clock; the sequencer pops one byte at a time and
// hands it to uart_tx with a single-cycle enable pulse, then follows the
// uart_tx_busy handshake (rise, then fall) before launching the next byte.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   wr_en         in   write strobe, one byte per cycle
//   wr_data[7:0]  in   byte to enqueue
//   flush         in   synchronous FIFO clear (does not abort a launched byte)
//   full          out  FIFO holds DEPTH bytes (registered)
//   fifo_cnt      out  bytes currently stored, 0..DEPTH
//   ovf           out  one-cycle pulse: a write was dropped because FIFO full
//   uart_tx_busy  in   busy flag from uart_tx
//   uart_tx_en    out  one-cycle launch pulse to uart_tx
//   uart_tx_data  out  launched byte, held until the next launch
//   tx_done       out  one-cycle pulse when busy falls after a launch
//   hs_err        out  one-cycle pulse when busy never rose within BUSY_TMO
// -----------------------------------------------------------------------------
module uart_tx_buf #(
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int BUSY_TMO = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   input  logic              flush,
   output logic              full,
   output logic [ADDR_W:0]   fifo_cnt,
   output logic              ovf,
   input  logic              uart_tx_busy,
   output logic              uart_tx_en,
   output logic [7:0]        uart_tx_data,
   output logic              tx_done,
   output logic              hs_err
);

   // The timeout counter only has to hold 0..BUSY_TMO-1: the cycle that would
   // reach BUSY_TMO is the one that leaves WAIT_HI.
   localparam int                TMO_W     = (BUSY_TMO < 2) ? 1 : $clog2(BUSY_TMO);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(BUSY_TMO - 1);
   localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LAUNCH  = 2'd1,
      S_WAIT_HI = 2'd2,
      S_WAIT_LO = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [7:0]          r_mem [DEPTH];
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W-1:0]   r_rd_ptr;
   logic [ADDR_W:0]     r_cnt;
   logic [ADDR_W:0]     w_cnt_nxt;
   logic                r_full;
   logic                r_ovf;
   logic                r_tx_en;
   logic [7:0]          r_tx_data;
   logic                r_done;
   logic                r_err;
   logic [TMO_W-1:0]    r_tmo;

   logic                w_push;
   logic                w_pop;
   logic                w_tmo_clr;
   logic                w_tmo_inc;
   logic                w_done_set;
   logic                w_err_set;

   // Full is judged on the registered flag, so a write while full is dropped
   // even when the sequencer pops in the same cycle. Flush wins over a write.
   assign w_push = wr_en & ~r_full & ~flush;

   // ---------------------------------------------------------------------------
   // Sequencer: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Sequencer: next state and per-cycle actions
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_tmo_clr   = 1'b0;
      w_tmo_inc   = 1'b0;
      w_done_set  = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Flush is held off here so a pop never races a pointer clear.
            if ((r_cnt != '0) && !uart_tx_busy && !flush) begin
               w_state_nxt = S_LAUNCH;
               w_pop       = 1'b1;
            end
         end
         S_LAUNCH: begin
            w_state_nxt = S_WAIT_HI;
            w_tmo_clr   = 1'b1;
         end
         S_WAIT_HI: begin
            if (uart_tx_busy) begin
               w_state_nxt = S_WAIT_LO;
            end else if (r_tmo == TMO_LAST) begin
               // The byte is considered consumed; it is not retried.
               w_state_nxt = S_IDLE;
               w_err_set   = 1'b1;
            end else begin
               w_tmo_inc   = 1'b1;
            end
         end
         S_WAIT_LO: begin
            if (!uart_tx_busy) begin
               w_state_nxt = S_IDLE;
               w_done_set  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Occupancy: never above DEPTH (push gated by full), never below 0 (pop
   // gated by a non-zero count).
   // ---------------------------------------------------------------------------
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (flush) begin
         w_cnt_nxt = '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + (ADDR_W + 1)'(1);
            2'b01:   w_cnt_nxt = r_cnt - (ADDR_W + 1)'(1);
            default: w_cnt_nxt = r_cnt;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Pointers, flags and launch outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_cnt     <= '0;
         r_full    <= 1'b0;
         r_ovf     <= 1'b0;
         r_tx_en   <= 1'b0;
         r_tx_data <= 8'h00;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_tmo     <= '0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_full  <= (w_cnt_nxt == DEPTH_CNT);
         r_ovf   <= wr_en & r_full & ~flush;
         r_tx_en <= w_pop;
         r_done  <= w_done_set;
         r_err   <= w_err_set;

         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
         end

         if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr];
         end

         if (w_tmo_clr) begin
            r_tmo <= '0;
         end else if (w_tmo_inc) begin
            r_tmo <= r_tmo + TMO_W'(1);
         end
      end
   end

   // Storage carries no reset; only locations behind a valid count are read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   assign full         = r_full;
   assign fifo_cnt     = r_cnt;
   assign ovf          = r_ovf;
   assign uart_tx_en   = r_tx_en;
   assign uart_tx_data = r_tx_data;
   assign tx_done      = r_done;
   assign hs_err       = r_err;

endmodule

// File: tb/tb_uart_tx_buf.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buf
//
// Bench for uart_tx_buf: a cycle table with hand-driven busy, then directed
// and randomized traffic against a transaction-level model (byte queue plus a
// simple uart_tx responder that raises busy for a frame or ignores a launch).
// -----------------------------------------------------------------------------
module tb_uart_tx_buf;

   localparam int DEPTH    = 16;
   localparam int ADDR_W   = 4;
   localparam int BUSY_TMO = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wr_en = 1'b0;
   logic [7:0]        wr_data = 8'h00;
   logic              flush = 1'b0;
   logic              uart_tx_busy = 1'b0;
   logic              full;
   logic [ADDR_W:0]   fifo_cnt;
   logic              ovf;
   logic              uart_tx_en;
   logic [7:0]        uart_tx_data;
   logic              tx_done;
   logic              hs_err;

   always #10 clk = ~clk;

   uart_tx_buf #(
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .BUSY_TMO(BUSY_TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .flush       (flush),
      .full        (full),
      .fifo_cnt    (fifo_cnt),
      .ovf         (ovf),
      .uart_tx_busy(uart_tx_busy),
      .uart_tx_en  (uart_tx_en),
      .uart_tx_data(uart_tx_data),
      .tx_done     (tx_done),
      .hs_err      (hs_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- cycle table ----------------
   typedef struct packed {
      logic            wr;
      logic [7:0]      d;
      logic            fl;
      logic            busy;
      logic [ADDR_W:0] cnt;
      logic            full;
      logic            ovf;
      logic            en;
      logic [7:0]      data;
      logic            done;
      logic            err;
   } vec_t;

   function automatic vec_t mk(logic wr, logic [7:0] d, logic fl, logic busy,
                               logic [ADDR_W:0] cnt, logic fu, logic ov, logic en,
                               logic [7:0] data, logic dn, logic er);
      vec_t v;
      v.wr = wr; v.d = d; v.fl = fl; v.busy = busy;
      v.cnt = cnt; v.full = fu; v.ovf = ov; v.en = en;
      v.data = data; v.done = dn; v.err = er;
      return v;
   endfunction

   vec_t tv[$];

   // ---------------- reference model ----------------
   bit         model_on    = 1'b0;
   bit         force_busy  = 1'b0;
   logic [7:0] q[$];
   logic [7:0] rx_q[$];
   bit         outstanding = 1'b0;
   bit         ign_pending = 1'b0;
   int         err_due     = 0;
   int         busy_left   = 0;
   bit         prev_busy   = 1'b0;
   int         cyc         = 0;
   int         frame_min   = 2;
   int         frame_max   = 2;
   int         ign_pct     = 0;

   // Called at a falling edge: the inputs still on the wires are the ones the
   // DUT sampled at the preceding rising edge.
   task automatic score();
      int         pre;
      logic       e_ovf;
      logic       e_done;
      logic       e_err;
      logic [7:0] b;
      pre    = q.size();
      e_ovf  = wr_en && !flush && (pre == DEPTH);
      e_done = outstanding && !ign_pending && prev_busy && !uart_tx_busy;
      e_err  = ign_pending && (cyc == err_due);
      if (e_done || e_err) begin
         outstanding = 1'b0;
         ign_pending = 1'b0;
      end
      if (flush) q.delete();
      else if (wr_en && pre < DEPTH) q.push_back(wr_data);
      if (uart_tx_en) begin
         chk("en_overlap", outstanding, 0);
         chk("en_while_busy", uart_tx_busy, 0);
         chk("pop_avail", (q.size() != 0), 1);
         if (q.size() != 0) begin
            b = q.pop_front();
            chk("tx_data", uart_tx_data, b);
         end
         rx_q.push_back(uart_tx_data);
         outstanding = 1'b1;
         if ($urandom_range(99) < ign_pct) begin
            ign_pending = 1'b1;
            err_due     = cyc + 1 + BUSY_TMO;
            busy_left   = 0;
         end else begin
            busy_left = $urandom_range(frame_max, frame_min);
         end
      end
      chk("ovf", ovf, e_ovf);
      chk("fifo_cnt", fifo_cnt, q.size());
      chk("full", full, (q.size() == DEPTH));
      chk("tx_done", tx_done, e_done);
      chk("hs_err", hs_err, e_err);
      prev_busy = uart_tx_busy;
      if (busy_left > 0) begin
         uart_tx_busy = 1'b1;
         busy_left--;
      end else begin
         uart_tx_busy = force_busy;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (model_on) score();
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      int n;
      n = 0;
      while ((q.size() != 0 || outstanding || uart_tx_busy) && n < max_cyc) begin
         tick();
         n++;
      end
      chk(name, (n < max_cyc), 1);
   endtask

   task automatic wait_busy(input string name);
      int n;
      n = 0;
      while (!uart_tx_busy && n < 50) begin
         tick();
         n++;
      end
      chk(name, uart_tx_busy, 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_full"}, full, 0);
      chk({tag, "_cnt"}, fifo_cnt, 0);
      chk({tag, "_ovf"}, ovf, 0);
      chk({tag, "_en"}, uart_tx_en, 0);
      chk({tag, "_data"}, uart_tx_data, 0);
      chk({tag, "_done"}, tx_done, 0);
      chk({tag, "_err"}, hs_err, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;

      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      chk_all_zero("rst");
      rst_n = 1'b1;

      // ---------------- cycle table ----------------
      //              wr  d     fl busy  cnt full ovf en data   done err
      tv.push_back(mk(1, 8'h55, 0, 0,    1,  0,   0,  0, 8'h00, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  1, 8'h55, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  0, 8'h55, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 1,    0,  0,   0,  0, 8'h55, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 1,    0,  0,   0,  0, 8'h55, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  0, 8'h55, 1,   0));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  0, 8'h55, 0,   0));
      tv.push_back(mk(1, 8'h3C, 0, 0,    1,  0,   0,  0, 8'h55, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  1, 8'h3C, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  0, 8'h3C, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  0, 8'h3C, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  0, 8'h3C, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  0, 8'h3C, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  0, 8'h3C, 0,   1));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  0, 8'h3C, 0,   0));
      tv.push_back(mk(1, 8'hA5, 0, 1,    1,  0,   0,  0, 8'h3C, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 1,    1,  0,   0,  0, 8'h3C, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  1, 8'hA5, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 1,    0,  0,   0,  0, 8'hA5, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 1,    0,  0,   0,  0, 8'hA5, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  0, 8'hA5, 1,   0));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  0, 8'hA5, 0,   0));
      tv.push_back(mk(1, 8'h77, 0, 0,    1,  0,   0,  0, 8'hA5, 0,   0));
      tv.push_back(mk(1, 8'h88, 1, 0,    0,  0,   0,  0, 8'hA5, 0,   0));
      tv.push_back(mk(0, 8'h00, 0, 0,    0,  0,   0,  0, 8'hA5, 0,   0));

      for (int i = 0; i < tv.size(); i++) begin
         wr_en        = tv[i].wr;
         wr_data      = tv[i].d;
         flush        = tv[i].fl;
         uart_tx_busy = tv[i].busy;
         tick();
         chk($sformatf("tv%0d_cnt", i),  fifo_cnt,     tv[i].cnt);
         chk($sformatf("tv%0d_full", i), full,         tv[i].full);
         chk($sformatf("tv%0d_ovf", i),  ovf,          tv[i].ovf);
         chk($sformatf("tv%0d_en", i),   uart_tx_en,   tv[i].en);
         chk($sformatf("tv%0d_data", i), uart_tx_data, tv[i].data);
         chk($sformatf("tv%0d_done", i), tx_done,      tv[i].done);
         chk($sformatf("tv%0d_err", i),  hs_err,       tv[i].err);
      end
      wr_en = 1'b0; flush = 1'b0; uart_tx_busy = 1'b0;
      model_on = 1'b1;

      // ---------------- burst to full, overflow, ordered drain ----------------
      base = rx_q.size();
      force_busy = 1'b1; uart_tx_busy = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         tick();
      end
      chk("burst_full", full, 1);
      chk("burst_cnt", fifo_cnt, 16);
      wr_data = 8'hAA;
      tick();
      chk("burst_ovf", ovf, 1);
      chk("burst_cnt_after_ovf", fifo_cnt, 16);
      wr_en = 1'b0;
      force_busy = 1'b0;
      frame_min = 3; frame_max = 6;
      tick();
      wait_idle("burst_drain", 2000);
      chk("burst_launches", rx_q.size() - base, 16);
      for (int i = 0; i < 16; i++)
         if (base + i < rx_q.size()) chk($sformatf("burst_ord%0d", i), rx_q[base + i], i);

      // ---------------- trickle writes while draining (pointer wrap) ----------
      base = rx_q.size();
      frame_min = 3; frame_max = 4;
      for (int i = 0; i < 20; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         tick();
         wr_en = 1'b0;
         tick();
         tick();
      end
      wait_idle("wrap_drain", 2000);
      chk("wrap_launches", rx_q.size() - base, 20);
      for (int i = 0; i < 20; i++)
         if (base + i < rx_q.size()) chk($sformatf("wrap_ord%0d", i), rx_q[base + i], i);

      // ---------------- flush during first byte's busy window ----------------
      base = rx_q.size();
      frame_min = 30; frame_max = 30;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
         tick();
      end
      wr_en = 1'b0;
      wait_busy("flush_busy_rose");
      tick();
      tick();
      flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
      tick();
      flush = 1'b0; wr_en = 1'b0;
      chk("flush_cnt", fifo_cnt, 0);
      chk("flush_no_ovf", ovf, 0);
      wait_idle("flush_drain", 200);
      repeat (20) tick();
      chk("flush_launches", rx_q.size() - base, 1);

      // ---------------- flush beats a write while full ----------------
      base = rx_q.size();
      force_busy = 1'b1; uart_tx_busy = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h40 + i);
         tick();
      end
      chk("fullflush_pre_full", full, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0; wr_en = 1'b0;
      chk("fullflush_ovf", ovf, 0);
      chk("fullflush_cnt", fifo_cnt, 0);
      chk("fullflush_full", full, 0);
      force_busy = 1'b0;
      repeat (10) tick();
      chk("fullflush_launches", rx_q.size() - base, 0);

      // ---------------- randomized traffic with occasional ignored launches --
      frame_min = 2; frame_max = 8; ign_pct = 10;
      for (int c = 0; c < 3000; c++) begin
         wr_en   = ($urandom_range(99) < (((c / 300) % 2) != 0 ? 85 : 20));
         wr_data = 8'($urandom);
         flush   = ($urandom_range(255) == 0);
         tick();
      end
      wr_en = 1'b0; flush = 1'b0;
      wait_idle("rand_drain", 3000);
      ign_pct = 0;

      // ---------------- reset mid-WAIT_LO with bytes queued ----------------
      frame_min = 60; frame_max = 60;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h90 + i);
         tick();
      end
      wr_en = 1'b0;
      wait_busy("rst_busy_rose");
      repeat (4) tick();
      chk("rst_pre_cnt", fifo_cnt, 3);
      model_on = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      uart_tx_busy = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      q.delete();
      outstanding = 1'b0; ign_pending = 1'b0; busy_left = 0; prev_busy = 1'b0;
      force_busy = 1'b0;
      model_on = 1'b1;
      base = rx_q.size();
      repeat (20) tick();
      chk("post_rst_no_launch", rx_q.size() - base, 0);
      frame_min = 3; frame_max = 3;
      wr_en = 1'b1; wr_data = 8'h5A;
      tick();
      wr_en = 1'b0;
      wait_idle("post_rst_drain", 200);
      chk("post_rst_launches", rx_q.size() - base, 1);
      if (rx_q.size() > base) chk("post_rst_byte", rx_q[base], 8'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
